// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Pops a synchronous FIFO (1-cycle read latency) into a
//                2-entry skid buffer and presents a framed valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       buf_level
);

    localparam int                 c_CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PKT_LEN - 1);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    logic [1:0]         r_occ;
    logic               r_inflight;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;

    logic               w_pop;
    logic [2:0]         w_fill;

    assign w_pop  = m_valid & m_ready;
    // Occupancy next cycle, counting the word already requested from the FIFO.
    assign w_fill = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign fifo_rd   = en & ~fifo_empty & ~rst & (w_fill <= 3'd1);
    assign m_valid   = (r_occ != c_ST_EMPTY);
    assign m_data    = r_head;
    assign m_last    = m_valid & (r_cnt == c_CNT_MAX);
    assign buf_level = r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= c_ST_EMPTY;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= fifo_rd;
            r_occ      <= w_fill[1:0];

            if (w_pop) begin
                r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_W'(1);
            end

            // Head always holds the oldest word; arriving data lands behind it.
            case (r_occ)
                c_ST_EMPTY: begin
                    if (r_inflight) r_head <= fifo_data;
                end
                c_ST_ONE: begin
                    if (r_inflight) begin
                        if (w_pop) r_head <= fifo_data;
                        else       r_tail <= fifo_data;
                    end
                end
                c_ST_TWO: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (r_inflight) r_tail <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed and soak bench for fifo_stream_reader with a
//                behavioural FIFO model and an in-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int c_WIDTH   = 8;
    localparam int c_PKT_LEN = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               fifo_rst;
    logic               en;
    logic               fifo_empty = 1'b1;
    logic [c_WIDTH-1:0] fifo_data  = '0;
    logic               fifo_rd;
    logic               m_valid;
    logic               m_ready;
    logic [c_WIDTH-1:0] m_data;
    logic               m_last;
    logic [1:0]         buf_level;

    logic               wr_en;
    logic [c_WIDTH-1:0] wr_data;

    logic [c_WIDTH-1:0] fifo_q[$];
    logic [c_WIDTH-1:0] exp_q[$];
    int                 rd_cyc_q[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    int pop_cnt = 0;
    int sb_cnt  = 0;
    bit lat_chk = 1'b0;

    fifo_stream_reader #(
        .WIDTH   (c_WIDTH),
        .PKT_LEN (c_PKT_LEN)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .buf_level  (buf_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Synchronous FIFO with registered read data; also records the write order.
    always @(posedge clk) begin
        if (fifo_rst) begin
            fifo_q.delete();
            exp_q.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
            if (wr_en) begin
                fifo_q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Scoreboard: order, framing, latency and read-strobe legality.
    always @(negedge clk) begin
        if (rst) begin
            sb_cnt <= 0;
        end else begin
            check("rd_while_empty", fifo_rd & fifo_empty, 0);
            check("occ_le2", buf_level <= 2'd2, 1);
            if (fifo_rd) begin
                rd_cnt <= rd_cnt + 1;
                rd_cyc_q.push_back(cyc);
            end
            if (m_valid && m_ready) begin
                pop_cnt <= pop_cnt + 1;
                if (exp_q.size() == 0) check("sb_extra_word", 0, 1);
                else                   check("sb_data", m_data, exp_q.pop_front());
                check("sb_last", m_last, sb_cnt == c_PKT_LEN - 1);
                sb_cnt <= (sb_cnt + 1) % c_PKT_LEN;
                if (lat_chk) begin
                    if (rd_cyc_q.size() == 0) check("lat_no_rd", 0, 1);
                    else                      check("lat", cyc, rd_cyc_q.pop_front() + 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [c_WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int rd_base;
        int pop_base;
        int n;

        rst      = 1'b1;
        fifo_rst = 1'b0;
        en       = 1'b1;
        m_ready  = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        tick();

        // T1: reset held while the FIFO fills and downstream is ready
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h10 + i));
        @(negedge clk);
        check("t1_rd", fifo_rd, 0);
        check("t1_valid", m_valid, 0);
        check("t1_last", m_last, 0);
        check("t1_level", buf_level, 0);
        check("t1_data", m_data, 0);

        // T2: full-rate stream
        tick();
        lat_chk = 1'b1;
        rd_cyc_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_rd", fifo_rd, (i < 8) ? 1 : 0);
            if (i >= 2) begin
                check("t2_valid", m_valid, 1);
                check("t2_data", m_data, 8'h10 + i - 2);
                check("t2_last", m_last, ((i - 2) % 4) == 3);
            end else begin
                check("t2_valid_early", m_valid, 0);
            end
        end
        @(negedge clk);
        check("t2_idle", m_valid, 0);

        // T3: backpressure
        tick();
        lat_chk  = 1'b0;
        m_ready  = 1'b0;
        rd_base  = rd_cnt;
        pop_base = pop_cnt;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h10 + i));
        repeat (3) tick();
        @(negedge clk);
        check("t3_rd_pulses", rd_cnt - rd_base, 2);
        check("t3_level", buf_level, 2);
        check("t3_hold_data", m_data, 8'h10);
        check("t3_hold_valid", m_valid, 1);
        check("t3_no_rd", fifo_rd, 0);
        tick();
        m_ready = 1'b1;
        repeat (14) tick();
        check("t3_drained", exp_q.size(), 0);
        check("t3_pops", pop_cnt - pop_base, 8);

        // T4: sparse FIFO
        lat_chk = 1'b1;
        rd_cyc_q.delete();
        pop_base = pop_cnt;
        for (int k = 0; k < 6; k++) begin
            fifo_write(8'(8'h20 + k));
            repeat (2) tick();
        end
        repeat (4) tick();
        lat_chk = 1'b0;
        check("t4_pops", pop_cnt - pop_base, 6);
        check("t4_drained", exp_q.size(), 0);

        // T5: enable dropped after the third read
        en = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h10 + i));
        @(negedge clk);
        check("t5_en_off_rd", fifo_rd, 0);
        tick();
        rd_base  = rd_cnt;
        pop_base = pop_cnt;
        en = 1'b1;
        n  = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (fifo_rd) n++;
        end
        tick();
        en = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("t5_rd_count", rd_cnt - rd_base, 3);
        check("t5_pops", pop_cnt - pop_base, 3);
        check("t5_idle_valid", m_valid, 0);
        check("t5_idle_rd", fifo_rd, 0);
        tick();
        en = 1'b1;
        repeat (14) tick();
        check("t5_resume_pops", pop_cnt - pop_base, 8);
        check("t5_drained", exp_q.size(), 0);

        // T6: reset two words into a packet
        en = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h50 + i));
        en = 1'b1;
        n  = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) n++;
        end
        check("t6_wait_pops", n, 2);
        tick();
        rst      = 1'b1;
        fifo_rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_level", buf_level, 0);
        check("t6_rst_valid", m_valid, 0);
        tick();
        rst      = 1'b0;
        fifo_rst = 1'b0;
        en       = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h40 + i));
        en = 1'b1;
        n  = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                n++;
                check("t6_last", m_last, (n == 4) || (n == 8));
                check("t6_data", m_data, 8'h40 + n - 1);
            end
        end
        check("t6_words", n, 8);

        // Random soak
        tick();
        for (int i = 0; i < 10000; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_data = 8'($urandom);
            tick();
        end
        wr_en   = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20000 && (exp_q.size() != 0 || m_valid); i++) tick();
        repeat (4) tick();
        check("soak_drained", exp_q.size(), 0);
        check("soak_idle", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
